regfile_write_port: RTL and testbench

REGFILE_WRITE_PORT -- requirements
Module: regfile_write_port

---
 rtl/regfile_write_port.sv | 96 +++++++++
 tb/tb_regfile_write_port.sv | 120 ++++++++++++
 2 files changed

// File: rtl/regfile_write_port.sv
// Write side of a 32-entry register file with one hardwired-zero entry.
// Latency: wr_en is combinational; a write is visible on regs right after the capturing edge.
// Backpressure: none; every enabled write is accepted, and reset overrides any write in its cycle.
module regfile_write_port #(
    parameter int DATA_W   = 64,
    parameter int ZERO_REG = 31
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   RegWrite,
    input  logic [4:0]             WriteRegister,
    input  logic [DATA_W-1:0]      WriteData,
    output logic [31:0]            wr_en,
    output logic [32*DATA_W-1:0]   regs
);

    localparam int NUM_REGS = 32;

    // First decode level: the upper two index bits pick one group of eight.
    // RegWrite gates this stage, so an idle cycle yields all-zero strobes no
    // matter what sits on WriteRegister, X included.
    logic [3:0] grp_sel;
    // Second decode level: the lower three index bits pick one entry in the group.
    logic [7:0] ent_sel;

    // 2:4 group decoder, enabled by RegWrite.
    always_comb begin
        grp_sel = 4'b0000;
        if (RegWrite) begin
            case (WriteRegister[4:3])
                2'd0:    grp_sel = 4'b0001;
                2'd1:    grp_sel = 4'b0010;
                2'd2:    grp_sel = 4'b0100;
                2'd3:    grp_sel = 4'b1000;
                default: grp_sel = 4'b0000;
            endcase
        end
    end

    // 3:8 entry decoder; unknown index bits fall to the all-zero default.
    always_comb begin
        ent_sel = 8'h00;
        case (WriteRegister[2:0])
            3'd0:    ent_sel = 8'h01;
            3'd1:    ent_sel = 8'h02;
            3'd2:    ent_sel = 8'h04;
            3'd3:    ent_sel = 8'h08;
            3'd4:    ent_sel = 8'h10;
            3'd5:    ent_sel = 8'h20;
            3'd6:    ent_sel = 8'h40;
            3'd7:    ent_sel = 8'h80;
            default: ent_sel = 8'h00;
        endcase
    end

    // Combine both levels into the one-hot strobe; the zero entry never strobes.
    always_comb begin
        wr_en = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i != ZERO_REG) begin
                wr_en[i] = grp_sel[i/8] & ent_sel[i%8];
            end
        end
    end

    // Storage: one enable-muxed bank of flops per entry, except the zero entry,
    // which is a constant and therefore cannot be disturbed by any write.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        if (g == ZERO_REG) begin : g_zero
            assign regs[g*DATA_W +: DATA_W] = '0;
        end else begin : g_store
            logic [DATA_W-1:0] data_d;
            logic [DATA_W-1:0] data_q;

            // Next value: load on strobe, otherwise recirculate.
            always_comb begin
                data_d = data_q;
                if (wr_en[g]) begin
                    data_d = WriteData;
                end
            end

            // Capture on the rising edge; reset wins over a same-cycle write.
            always_ff @(posedge clk) begin
                if (reset) begin
                    data_q <= '0;
                end else begin
                    data_q <= data_d;
                end
            end

            assign regs[g*DATA_W +: DATA_W] = data_q;
        end
    end

endmodule

// File: tb/tb_regfile_write_port.sv
// Scoreboarded bench for regfile_write_port: every driven cycle pushes the
// expected register image, which is popped and compared after the edge.
// wr_en is compared combinationally in the same cycle the stimulus is applied.
module tb_regfile_write_port;

    localparam int DATA_W = 64;
    localparam int ZR     = 31;

    typedef logic [31:0][DATA_W-1:0] snap_t;

    logic                  clk;
    logic                  reset;
    logic                  RegWrite;
    logic [4:0]            WriteRegister;
    logic [DATA_W-1:0]     WriteData;
    logic [31:0]           wr_en;
    logic [32*DATA_W-1:0]  regs;

    regfile_write_port #(.DATA_W(DATA_W), .ZERO_REG(ZR)) dut (
        .clk           (clk),
        .reset         (reset),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .wr_en         (wr_en),
        .regs          (regs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_fail   = 0;
    snap_t model;
    snap_t sb_q[$];

    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Apply one cycle of stimulus, check the strobe, advance the model,
    // then compare the popped expectation against regs after the edge.
    task automatic step(input logic rst, input logic we, input logic [4:0] idx,
                        input logic [DATA_W-1:0] dat, input string tag);
        logic [31:0] exp_en;
        snap_t       exp_img;
        reset         = rst;
        RegWrite      = we;
        WriteRegister = idx;
        WriteData     = dat;
        #1;
        exp_en = '0;
        if (we === 1'b1 && idx !== 5'd31) exp_en[idx] = 1'b1;
        check({tag, ".wr_en"}, {32'd0, wr_en}, {32'd0, exp_en});
        if (rst) model = '0;
        else if (we === 1'b1 && idx !== 5'd31) model[idx] = dat;
        sb_q.push_back(model);
        @(posedge clk);
        #1;
        exp_img = sb_q.pop_front();
        for (int i = 0; i < 32; i++) begin
            check($sformatf("%s.reg%0d", tag, i), regs[i*DATA_W +: DATA_W], exp_img[i]);
        end
    endtask

    initial begin
        reset = 1'b1; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
        model = '0;
        @(posedge clk); #1;

        // Reset for two cycles with RegWrite low.
        step(1'b1, 1'b0, 5'd0, 64'd0, "rst0");
        step(1'b1, 1'b0, 5'd0, 64'd0, "rst1");

        // Idle with unknown index must not strobe.
        step(1'b0, 1'b0, 5'bxxxxx, {DATA_W{1'bx}}, "idle_x");

        // Write sweep over all indices, including the hardwired one.
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 1'b1, 5'(i), 64'h0123_4567_89AB_0000 + 64'(i), $sformatf("sweep%0d", i));
        end
        step(1'b0, 1'b0, 5'd0, 64'd0, "sweep_read");

        // Hold: one write then ten idle cycles with random inputs.
        step(1'b0, 1'b1, 5'd5, 64'hDEADBEEF_CAFEF00D, "hold_wr");
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b0, 5'($urandom_range(0, 31)), {$urandom, $urandom}, $sformatf("hold%0d", k));
        end

        // Back-to-back writes to the same index.
        step(1'b0, 1'b1, 5'd7, 64'h1, "b2b1");
        step(1'b0, 1'b1, 5'd7, 64'h2, "b2b2");
        step(1'b0, 1'b1, 5'd7, 64'h3, "b2b3");

        // Reset colliding with a write, then the first write after reset.
        step(1'b0, 1'b1, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, "coll_pre");
        step(1'b1, 1'b1, 5'd3, 64'hAAAA, "coll_rst");
        step(1'b0, 1'b1, 5'd3, 64'hAAAA, "coll_post");

        // Populate a few entries, then hammer the zero register.
        step(1'b0, 1'b1, 5'd0,  64'h1111, "zr_seed0");
        step(1'b0, 1'b1, 5'd30, 64'h3030, "zr_seed30");
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, $sformatf("zr%0d", k));
        end

        // Mid-sequence reset clears everything in one edge.
        step(1'b1, 1'b0, 5'd0, 64'd0, "mid_rst");
        step(1'b0, 1'b1, 5'd12, 64'h5A5A_0000_1234_5678, "post_rst_wr");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
